// File: rtl/dma64_arbiter.sv
// Round-robin arbiter sharing one DMA64 engine between NREQ requesters.
// A grant covers a whole tx burst plus the engine's rx response up to rx_last.

package dma64_pkg;

  typedef struct packed {
    logic        rx_ready;
    logic [63:0] tx_data;
    logic [7:0]  tx_strob;
    logic        tx_last;
    logic        tx_valid;
  } dma64_in_type;

  typedef struct packed {
    logic        tx_ready;
    logic [63:0] rx_data;
    logic        rx_last;
    logic        rx_valid;
    logic        busy;
  } dma64_out_type;

endpackage

module dma64_arbiter_chk #(
  parameter int NREQ = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  input logic [NREQ-1:0] grant,
  input logic            busy,
  input logic            dma_tx_valid,
  input logic [NREQ-1:0] req_tx_ready,
  input logic [NREQ-1:0] req_rx_valid
);

  a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(grant));

  a_busy_matches_grant: assert property (@(posedge i_clk) disable iff (i_rst)
    busy == (grant != '0));

  a_tx_valid_only_busy: assert property (@(posedge i_clk) disable iff (i_rst)
    dma_tx_valid |-> busy);

  a_ready_only_owner: assert property (@(posedge i_clk) disable iff (i_rst)
    (req_tx_ready & ~grant) == '0);

  a_rx_valid_only_owner: assert property (@(posedge i_clk) disable iff (i_rst)
    (req_rx_valid & ~grant) == '0);

endmodule

module dma64_arbiter
  import dma64_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_tx_valid,
  input  logic [NREQ*64-1:0]   i_req_tx_data,
  input  logic [NREQ*8-1:0]    i_req_tx_strob,
  input  logic [NREQ-1:0]      i_req_tx_last,
  output logic [NREQ-1:0]      o_req_tx_ready,
  output logic [NREQ-1:0]      o_req_rx_valid,
  output logic [63:0]          o_req_rx_data,
  output logic                 o_req_rx_last,
  input  logic [NREQ-1:0]      i_req_rx_ready,
  output dma64_in_type         o_dma,
  input  dma64_out_type        i_dma,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_RX   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [GW-1:0] g;
  logic [GW-1:0] g_n;
  logic [GW-1:0] p;
  logic [GW-1:0] p_n;
  logic          rx_done;
  logic          rx_done_n;

  logic [63:0]   tx_data_arr  [NREQ];
  logic [7:0]    tx_strob_arr [NREQ];

  logic          any_valid;
  logic [GW-1:0] winner;
  logic          found;
  logic [GW-1:0] cand;
  logic [GW-1:0] p_after;
  logic          owner_tx_valid;
  logic          owner_tx_last;
  logic          owner_rx_ready;
  logic          tx_hs;
  logic          rx_hs;
  logic          rx_last_hs;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign tx_data_arr[k]  = i_req_tx_data[64*k +: 64];
    assign tx_strob_arr[k] = i_req_tx_strob[8*k +: 8];
  end

  assign any_valid      = |i_req_tx_valid;
  assign owner_tx_valid = i_req_tx_valid[g];
  assign owner_tx_last  = i_req_tx_last[g];
  assign owner_rx_ready = i_req_rx_ready[g];
  assign p_after        = (int'(g) == NREQ - 1) ? '0 : g + GW'(1);

  // Handshakes are only meaningful while a requester owns the engine.
  assign tx_hs      = (state == S_TX) && owner_tx_valid && i_dma.tx_ready;
  assign rx_hs      = ((state == S_TX) || (state == S_RX)) && i_dma.rx_valid && owner_rx_ready;
  assign rx_last_hs = rx_hs && i_dma.rx_last;

  // Round-robin search: first valid requester at or after p, wrapping modulo NREQ.
  always_comb begin
    winner = p;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = GW'((int'(p) + i) % NREQ);
      if (!found && i_req_tx_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      g       <= '0;
      p       <= '0;
      rx_done <= 1'b0;
    end else begin
      state   <= state_n;
      g       <= g_n;
      p       <= p_n;
      rx_done <= rx_done_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n   = state;
    g_n       = g;
    p_n       = p;
    rx_done_n = rx_done;
    case (state)
      S_IDLE: begin
        if (any_valid && !i_dma.busy) begin
          state_n   = S_TX;
          g_n       = winner;
          rx_done_n = 1'b0;
        end else begin
          state_n   = S_IDLE;
        end
      end
      S_TX: begin
        if (rx_last_hs) begin
          rx_done_n = 1'b1;
        end else begin
          rx_done_n = rx_done;
        end
        // The response may already be complete, so RX can be skipped entirely.
        if (tx_hs && owner_tx_last) begin
          if (rx_done || rx_last_hs) begin
            state_n = S_IDLE;
            p_n     = p_after;
          end else begin
            state_n = S_RX;
          end
        end else begin
          state_n = S_TX;
        end
      end
      S_RX: begin
        if (rx_last_hs) begin
          state_n = S_IDLE;
          p_n     = p_after;
        end else begin
          state_n = S_RX;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Output steering: only the owner's channels are connected to the engine.
  always_comb begin
    o_dma          = '0;
    o_req_tx_ready = '0;
    o_req_rx_valid = '0;
    o_req_rx_data  = i_dma.rx_data;
    o_req_rx_last  = i_dma.rx_last;
    case (state)
      S_IDLE: begin
        o_dma = '0;
      end
      S_TX: begin
        o_dma.tx_valid    = owner_tx_valid;
        o_dma.tx_last     = owner_tx_last;
        o_dma.tx_data     = tx_data_arr[g];
        o_dma.tx_strob    = tx_strob_arr[g];
        o_dma.rx_ready    = owner_rx_ready;
        o_req_tx_ready[g] = i_dma.tx_ready;
        o_req_rx_valid[g] = i_dma.rx_valid;
      end
      S_RX: begin
        o_dma.rx_ready    = owner_rx_ready;
        o_req_rx_valid[g] = i_dma.rx_valid;
      end
      default: begin
        o_dma = '0;
      end
    endcase
  end

  // Grant vector and busy flag.
  always_comb begin
    o_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if ((state != S_IDLE) && (g == GW'(k))) begin
        o_grant[k] = 1'b1;
      end else begin
        o_grant[k] = 1'b0;
      end
    end
    o_busy = (state != S_IDLE);
  end

  dma64_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .grant        (o_grant),
    .busy         (o_busy),
    .dma_tx_valid (o_dma.tx_valid),
    .req_tx_ready (o_req_tx_ready),
    .req_rx_valid (o_req_rx_valid)
  );

endmodule

// File: tb/tb_dma64_arbiter.sv
// Directed bench for dma64_arbiter (NREQ=2): arbitration, burst hand-off,
// rx completion ordering, engine-busy gating, stalls and reset abandonment.

module tb_dma64_arbiter;
  import dma64_pkg::*;

  logic          clk;
  logic          rst;
  logic [1:0]    tx_valid;
  logic [127:0]  tx_data;
  logic [15:0]   tx_strob;
  logic [1:0]    tx_last;
  logic [1:0]    tx_ready_o;
  logic [1:0]    rx_valid_o;
  logic [63:0]   rx_data_o;
  logic          rx_last_o;
  logic [1:0]    rx_ready;
  dma64_in_type  dma_o;
  dma64_out_type dma_i;
  logic [1:0]    grant;
  logic          busy;

  int n_checks;
  int n_pass;

  dma64_arbiter #(.NREQ(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_tx_valid (tx_valid),
    .i_req_tx_data  (tx_data),
    .i_req_tx_strob (tx_strob),
    .i_req_tx_last  (tx_last),
    .o_req_tx_ready (tx_ready_o),
    .o_req_rx_valid (rx_valid_o),
    .o_req_rx_data  (rx_data_o),
    .o_req_rx_last  (rx_last_o),
    .i_req_rx_ready (rx_ready),
    .o_dma          (dma_o),
    .i_dma          (dma_i),
    .o_grant        (grant),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    tx_valid = 2'b00;
    tx_data  = '0;
    tx_strob = '0;
    tx_last  = 2'b00;
    rx_ready = 2'b00;
    dma_i    = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_tx_ready", 64'(tx_ready_o), 64'h0);
    chk("rst_rx_valid", 64'(rx_valid_o), 64'h0);
    chk("rst_dma_tx_valid", 64'(dma_o.tx_valid), 64'h0);
    chk("rst_p", 64'(dut.p), 64'h0);

    // Two-beat tx from req0, response arrives after the burst (TX -> RX -> IDLE)
    tx_valid        = 2'b01;
    tx_data[63:0]   = 64'h1111_0000_AAAA_0001;
    tx_strob[7:0]   = 8'hFF;
    dma_i.tx_ready  = 1'b1;
    #1;
    chk("arb_no_ready", 64'(tx_ready_o), 64'h0);
    chk("arb_no_dma_valid", 64'(dma_o.tx_valid), 64'h0);
    chk("arb_no_grant", 64'(grant), 64'h0);
    tick();
    chk("b1_grant", 64'(grant), 64'h1);
    chk("b1_busy", 64'(busy), 64'h1);
    chk("b1_dma_valid", 64'(dma_o.tx_valid), 64'h1);
    chk("b1_dma_data", dma_o.tx_data, 64'h1111_0000_AAAA_0001);
    chk("b1_dma_strob", 64'(dma_o.tx_strob), 64'hFF);
    chk("b1_tx_ready", 64'(tx_ready_o), 64'h1);
    tick();
    tx_data[63:0] = 64'h2222_0000_BBBB_0002;
    tx_strob[7:0] = 8'h0F;
    tx_last       = 2'b01;
    #1;
    chk("b2_dma_last", 64'(dma_o.tx_last), 64'h1);
    chk("b2_dma_data", dma_o.tx_data, 64'h2222_0000_BBBB_0002);
    chk("b2_dma_strob", 64'(dma_o.tx_strob), 64'h0F);
    tick();
    tx_valid = 2'b00;
    tx_last  = 2'b00;
    #1;
    chk("rx_state_busy", 64'(busy), 64'h1);
    chk("rx_state_grant", 64'(grant), 64'h1);
    chk("rx_state_no_tx", 64'(dma_o.tx_valid), 64'h0);
    chk("rx_state_no_ready", 64'(tx_ready_o), 64'h0);
    dma_i.rx_valid = 1'b1;
    dma_i.rx_last  = 1'b1;
    dma_i.rx_data  = 64'hCAFE_0000_1234_5678;
    rx_ready       = 2'b01;
    #1;
    chk("rx_valid_route", 64'(rx_valid_o), 64'h1);
    chk("rx_ready_route", 64'(dma_o.rx_ready), 64'h1);
    chk("rx_data_route", rx_data_o, 64'hCAFE_0000_1234_5678);
    tick();
    clear_inputs();
    dma_i.tx_ready = 1'b1;
    #1;
    chk("done_busy", 64'(busy), 64'h0);
    chk("done_grant", 64'(grant), 64'h0);
    chk("done_p", 64'(dut.p), 64'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_p", 64'(dut.p), 64'h0);

    // Both requesters continuously valid, single-beat transactions completing with rx_last
    tx_valid       = 2'b11;
    tx_last        = 2'b11;
    tx_data        = {64'hDDDD_0000_0000_0001, 64'hCCCC_0000_0000_0000};
    dma_i.rx_valid = 1'b1;
    dma_i.rx_last  = 1'b1;
    rx_ready       = 2'b11;
    #1;
    chk("rr_idle0", 64'(grant), 64'h0);
    tick();
    chk("rr_g0", 64'(grant), 64'h1);
    chk("rr_g0_ready", 64'(tx_ready_o), 64'h1);
    chk("rr_g0_rxv", 64'(rx_valid_o), 64'h1);
    chk("rr_g0_data", dma_o.tx_data, 64'hCCCC_0000_0000_0000);
    tick();
    chk("rr_idle1", 64'(grant), 64'h0);
    chk("rr_idle1_p", 64'(dut.p), 64'h1);
    tick();
    chk("rr_g1", 64'(grant), 64'h2);
    chk("rr_g1_ready", 64'(tx_ready_o), 64'h2);
    chk("rr_g1_data", dma_o.tx_data, 64'hDDDD_0000_0000_0001);
    tick();
    chk("rr_idle2", 64'(grant), 64'h0);
    tick();
    chk("rr_g0_again", 64'(grant), 64'h1);
    tick();
    clear_inputs();
    dma_i.tx_ready = 1'b1;
    #1;
    chk("rr_end_grant", 64'(grant), 64'h0);
    chk("rr_end_p", 64'(dut.p), 64'h1);

    // rx_last completes during TX, so the tx_last handshake goes straight to IDLE
    tx_valid = 2'b10;
    #1;
    tick();
    chk("early_grant", 64'(grant), 64'h2);
    dma_i.tx_ready = 1'b0;
    dma_i.rx_valid = 1'b1;
    dma_i.rx_last  = 1'b1;
    rx_ready       = 2'b10;
    #1;
    chk("early_rxv", 64'(rx_valid_o), 64'h2);
    chk("early_rx_ready", 64'(dma_o.rx_ready), 64'h1);
    tick();
    dma_i.rx_valid = 1'b0;
    dma_i.rx_last  = 1'b0;
    dma_i.tx_ready = 1'b1;
    tx_last        = 2'b10;
    #1;
    chk("early_still_tx", 64'(busy), 64'h1);
    chk("early_still_grant", 64'(grant), 64'h2);
    tick();
    clear_inputs();
    #1;
    chk("early_no_rx_busy", 64'(busy), 64'h0);
    chk("early_no_rx_grant", 64'(grant), 64'h0);
    chk("early_p", 64'(dut.p), 64'h0);

    // Engine busy holds off the grant
    dma_i.busy = 1'b1;
    tx_valid   = 2'b10;
    #1;
    chk("eng_busy0", 64'(grant), 64'h0);
    tick();
    chk("eng_busy1", 64'(grant), 64'h0);
    tick();
    chk("eng_busy2", 64'(grant), 64'h0);
    dma_i.busy = 1'b0;
    #1;
    chk("eng_free_same_cycle", 64'(grant), 64'h0);
    tick();
    chk("eng_free_grant", 64'(grant), 64'h2);

    // Owner stalls 3 cycles mid-burst while req0 waits; busy is ignored once granted
    dma_i.busy     = 1'b1;
    dma_i.tx_ready = 1'b1;
    tick();
    tx_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_grant", 64'(grant), 64'h2);
      chk("stall_dma_valid", 64'(dma_o.tx_valid), 64'h0);
      chk("stall_ready", 64'(tx_ready_o), 64'h2);
      tick();
    end
    tx_valid       = 2'b11;
    tx_last        = 2'b10;
    dma_i.rx_valid = 1'b1;
    dma_i.rx_last  = 1'b1;
    rx_ready       = 2'b10;
    #1;
    chk("resume_dma_valid", 64'(dma_o.tx_valid), 64'h1);
    chk("resume_grant", 64'(grant), 64'h2);
    tick();
    clear_inputs();
    #1;
    chk("stall_done_grant", 64'(grant), 64'h0);
    chk("stall_done_busy", 64'(busy), 64'h0);
    chk("stall_done_p", 64'(dut.p), 64'h0);

    // Reset while in RX with an rx beat pending
    tx_valid       = 2'b01;
    tx_last        = 2'b01;
    dma_i.tx_ready = 1'b1;
    #1;
    tick();
    tick();
    tx_valid       = 2'b00;
    tx_last        = 2'b00;
    dma_i.rx_valid = 1'b1;
    dma_i.rx_data  = 64'h0BAD_F00D_0000_0042;
    #1;
    chk("pre_rst_busy", 64'(busy), 64'h1);
    chk("pre_rst_rxv", 64'(rx_valid_o), 64'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_rxv", 64'(rx_valid_o), 64'h0);
    chk("mid_rst_p", 64'(dut.p), 64'h0);
    chk("mid_rst_rx_data", rx_data_o, 64'h0BAD_F00D_0000_0042);
    rst = 1'b0;
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma64_arbiter.md
DMA64_ARBITER -- requirements
Module: dma64_arbiter

Interface
REQ-001 Parameter: NREQ, 2, number of requesters sharing one DMA64 engine (legal 1..4).
REQ-002 Port: i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst  in  1  reset, synchronous, active-high.
REQ-004 Port: i_req_tx_valid  in  NREQ  per-requester tx beat valid.
REQ-005 Port: i_req_tx_data  in  NREQ*64  per-requester tx data, requester k at bits [64k+63:64k].
REQ-006 Port: i_req_tx_strob  in  NREQ*8  per-requester byte strobes, requester k at [8k+7:8k].
REQ-007 Port: i_req_tx_last  in  NREQ  per-requester last tx beat.
REQ-008 Port: o_req_tx_ready  out  NREQ  per-requester tx ready.
REQ-009 Port: o_req_rx_valid  out  NREQ  per-requester rx beat valid.
REQ-010 Port: o_req_rx_data  out  64  rx data, shared by all requesters.
REQ-011 Port: o_req_rx_last  out  1  rx last beat, shared by all requesters.
REQ-012 Port: i_req_rx_ready  in  NREQ  per-requester rx ready.
REQ-013 Port: o_dma  out  dma64_in_type  to engine: rx_ready, tx_data, tx_strob, tx_last, tx_valid.
REQ-014 Port: i_dma  in  dma64_out_type  from engine: tx_ready, rx_data, rx_last, rx_valid, busy.
REQ-015 Port: o_grant  out  NREQ  one-hot current owner; all-zero when idle.
REQ-016 Port: o_busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, TX, RX; registers: state, grant index g, round-robin pointer p, rx_done flag.
REQ-018 IDLE: when any i_req_tx_valid=1 and i_dma.busy=0, SHALL select first requester with valid set, searching from p upward modulo NREQ; next cycle g=winner, state=TX, rx_done=0.
REQ-019 IDLE: o_req_tx_ready=0, o_req_rx_valid=0, o_dma.tx_valid=0, o_dma.rx_ready=0; no beat transfers (arbitration costs exactly 1 cycle).
REQ-020 TX: o_dma.tx_valid/tx_data/tx_strob/tx_last SHALL equal requester g inputs combinationally; o_req_tx_ready[g]=i_dma.tx_ready; other ready bits 0.
REQ-021 TX and RX: o_req_rx_valid[g]=i_dma.rx_valid, others 0; o_dma.rx_ready=i_req_rx_ready[g]; o_req_rx_data=i_dma.rx_data and o_req_rx_last=i_dma.rx_last always.
REQ-022 Outside TX, o_dma.tx_valid/tx_last/tx_data/tx_strob SHALL be 0.
REQ-023 TX: rx handshake with rx_last SHALL set rx_done=1.
REQ-024 TX: tx handshake (tx_valid & tx_ready) with tx_last=1 SHALL go IDLE if rx_done=1 or an rx_last handshake occurs same cycle, else go RX.
REQ-025 RX: rx handshake with rx_last=1 SHALL go IDLE.
REQ-026 On every transition to IDLE, p SHALL become (g+1) mod NREQ; grant released same edge.
REQ-027 Requester g deasserting tx_valid mid-burst SHALL NOT release grant; no beat forwarded.
REQ-028 Non-granted requesters SHALL see ready=0 and rx_valid=0 for the whole transaction regardless of their valid.
REQ-029 i_dma.busy SHALL only gate new grants in IDLE; ignored in TX/RX.
REQ-030 NREQ=1: p stays 0; behaviour otherwise identical.
REQ-031 o_grant = one-hot(g) in TX/RX; o_busy = (state != IDLE).

Reset
REQ-032 i_rst=1 at a clock edge SHALL force state=IDLE, g=0, p=0, rx_done=0; from next cycle all outputs 0 (o_req_rx_data/o_req_rx_last follow i_dma per REQ-021).
REQ-033 Reset mid-transaction SHALL abandon the burst without completing any handshake; recovery of the engine is outside this block.

Verification
REQ-034 NREQ=2, req0 sends 2-beat tx (last on beat 2), engine returns 1 rx beat with rx_last -> grant=01 one cycle after valid, 2 tx beats forwarded, then IDLE, p=1.
REQ-035 req0 and req1 valid continuously, 3 single-beat transactions -> grants in order req0, req1, req0; each separated by one IDLE cycle.
REQ-036 rx_last handshake arrives in TX before tx_last -> on tx_last handshake FSM goes directly IDLE, no RX cycle.
REQ-037 i_dma.busy=1 with req1 valid -> o_grant stays 00 until busy drops, grant=10 next cycle.
REQ-038 i_rst=1 in RX with rx_valid pending -> next cycle o_busy=0, o_grant=00, o_req_rx_valid=00, p=0.
REQ-039 Granted requester drops tx_valid for 3 cycles mid-burst while other requester valid -> grant held, o_dma.tx_valid=0 those cycles, burst completes afterwards.
